// File: rtl/simm_dram_ctrl.sv
// SIMM DRAM controller: turns single-word valid/ready requests into RAS/CAS
// row/column sequences and interleaves periodic CAS-before-RAS refresh.
module simm_dram_ctrl #(
    parameter int MA_W         = 9,
    parameter int BANK_BITS    = 3,
    parameter int DATA_W       = 16,
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 2,
    parameter int T_RAS        = 3,
    parameter int REF_INTERVAL = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [BANK_BITS+2*MA_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [(2**BANK_BITS)-1:0]     ras_n,
    output logic                          cas_n,
    output logic                          we_n,
    output logic [MA_W-1:0]               ma,
    output logic [DATA_W-1:0]             dq_out,
    output logic                          dq_oe,
    input  logic [DATA_W-1:0]             dq_in
);
    localparam int NBANK = 2**BANK_BITS;
    localparam int AW    = BANK_BITS + 2*MA_W;
    localparam int TM1   = (T_RCD > T_CAS) ? T_RCD : T_CAS;
    localparam int TM2   = (T_RP > T_RAS) ? T_RP : T_RAS;
    localparam int TMAX  = (TM1 > TM2) ? TM1 : TM2;
    localparam int CNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int TMR_W = $clog2(REF_INTERVAL);

    typedef enum logic [2:0] {IDLE, ROW, COL, PRE, REF_CAS, REF_RAS} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [TMR_W-1:0]    timer;
    logic                ref_pending;
    logic                expire;
    logic [MA_W-1:0]     col_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;

    assign expire = (timer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            timer       <= TMR_W'(REF_INTERVAL-1);
            ref_pending <= 1'b0;
            col_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            ras_n       <= '1;
            cas_n       <= 1'b1;
            we_n        <= 1'b1;
            ma          <= '0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
        end else begin
            timer     <= expire ? TMR_W'(REF_INTERVAL-1) : timer - 1'b1;
            rsp_valid <= 1'b0;
            if (expire) ref_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (ref_pending) begin
                        // a fresh expiry on this same edge stays pending
                        state       <= REF_CAS;
                        ref_pending <= expire;
                        cas_n       <= 1'b0;
                        ras_n       <= '1;
                        we_n        <= 1'b1;
                        req_ready   <= 1'b0;
                    end else if (req_valid && req_ready) begin
                        state     <= ROW;
                        cnt       <= CNT_W'(T_RCD-1);
                        ras_n     <= ~(NBANK'(1) << req_addr[AW-1:2*MA_W]);
                        ma        <= req_addr[2*MA_W-1:MA_W];
                        col_q     <= req_addr[MA_W-1:0];
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        we_n      <= !req_we;
                        cas_n     <= 1'b1;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= !expire;
                    end
                end
                ROW: begin
                    if (cnt == '0) begin
                        state <= COL;
                        cnt   <= CNT_W'(T_CAS-1);
                        cas_n <= 1'b0;
                        ma    <= col_q;
                        dq_oe <= we_q;
                        if (we_q) dq_out <= wdata_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COL: begin
                    if (cnt == '0) begin
                        state     <= PRE;
                        cnt       <= CNT_W'(T_RP-1);
                        ras_n     <= '1;
                        cas_n     <= 1'b1;
                        we_n      <= 1'b1;
                        dq_oe     <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!we_q) rsp_rdata <= dq_in;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        req_ready <= !(ref_pending || expire);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REF_CAS: begin
                    state <= REF_RAS;
                    cnt   <= CNT_W'(T_RAS-1);
                    ras_n <= '0;
                end
                REF_RAS: begin
                    if (cnt == '0) begin
                        state <= PRE;
                        cnt   <= CNT_W'(T_RP-1);
                        ras_n <= '1;
                        cas_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simm_dram_ctrl.sv
// Randomized bench for simm_dram_ctrl: a schedule-level reference model predicts
// every strobe per cycle; responses go through a scoreboard queue.
module tb_simm_dram_ctrl;
    localparam int MA_W = 9, BANK_BITS = 3, DATA_W = 16;
    localparam int T_RCD = 2, T_CAS = 2, T_RP = 2, T_RAS = 3, RI = 64;
    localparam int ACC_LEN = T_RCD + T_CAS + T_RP;
    localparam int REF_LEN = 1 + T_RAS + T_RP;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [20:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  ras_n;
    logic        cas_n, we_n, dq_oe;
    logic [8:0]  ma;
    logic [15:0] dq_out, dq_in;

    simm_dram_ctrl #(
        .MA_W(MA_W), .BANK_BITS(BANK_BITS), .DATA_W(DATA_W), .T_RCD(T_RCD),
        .T_CAS(T_CAS), .T_RP(T_RP), .T_RAS(T_RAS), .REF_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .ma(ma), .dq_out(dq_out), .dq_oe(dq_oe),
        .dq_in(dq_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int lbl);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, lbl);
        end
    endtask

    // DRAM read data changes every cycle so a mistimed sample is visible
    function automatic logic [15:0] pat(int c);
        logic [31:0] t;
        t = c * 32'h9E3779B1;
        return t[31:16] ^ 16'h5A5A;
    endfunction

    typedef struct { int lbl; logic [15:0] rd; } rsp_t;
    rsp_t sb[$];

    // Reference model: edges counted from reset; an op started at edge s
    // occupies cycles s..s+len-1, next decision at edge s+len+1.
    int n = 0, free_e = 1, op = 0, start = 0;
    bit pending = 0, started = 0;
    logic [2:0]  m_bank;
    logic [8:0]  m_row, m_col;
    logic        m_we;
    logic [15:0] m_wd, last_rd = '0, exp_rd;
    logic [7:0]  e_ras;
    logic        e_cas, e_we, e_oe, e_ready, e_chk_ma, e_chk_dq, e_chk_rd;
    logic [8:0]  e_ma;
    logic [15:0] e_dq, e_rd;

    always @(posedge clk) begin
        int p;
        started = 1;
        if (rst) begin
            n = 0; free_e = 1; op = 0; pending = 0; last_rd = '0;
            sb.delete();
        end else begin
            n++;
            if (n >= free_e) begin
                if (pending) begin
                    op = 2; start = n; pending = 0; free_e = n + REF_LEN + 1;
                end else if (req_valid) begin
                    op = 1; start = n; free_e = n + ACC_LEN + 1;
                    m_bank = req_addr[20:18]; m_row = req_addr[17:9];
                    m_col = req_addr[8:0]; m_we = req_we; m_wd = req_wdata;
                    exp_rd = m_we ? last_rd : pat(n + T_RCD + T_CAS - 1);
                    last_rd = exp_rd;
                    sb.push_back('{n + T_RCD + T_CAS, exp_rd});
                end
            end
            if (n % RI == 0) pending = 1;
        end
        e_ras = 8'hFF; e_cas = 1; e_we = 1; e_oe = 0;
        e_chk_ma = rst; e_ma = '0; e_chk_dq = rst; e_dq = '0;
        e_chk_rd = rst; e_rd = '0;
        e_ready = rst ? 1'b1 : (n >= free_e - 1 && !pending);
        p = n - start + 1;
        if (!rst && op == 1 && p <= ACC_LEN) begin
            if (p <= T_RCD + T_CAS) begin
                e_ras = ~(8'd1 << m_bank); e_we = !m_we; e_chk_ma = 1;
                if (p <= T_RCD) begin
                    e_ma = m_row;
                end else begin
                    e_cas = 0; e_ma = m_col; e_oe = m_we; e_chk_dq = m_we; e_dq = m_wd;
                end
            end
        end else if (!rst && op == 2 && p <= REF_LEN) begin
            if (p == 1) e_cas = 0;
            else if (p <= 1 + T_RAS) begin e_cas = 0; e_ras = 8'h00; end
        end
    end

    // Monitor: per-cycle strobes plus scoreboard pop on rsp_valid
    always @(negedge clk) begin
        if (started) begin
            chk("ras_n", 32'(ras_n), 32'(e_ras), n);
            chk("cas_n", 32'(cas_n), 32'(e_cas), n);
            chk("we_n", 32'(we_n), 32'(e_we), n);
            chk("dq_oe", 32'(dq_oe), 32'(e_oe), n);
            chk("req_ready", 32'(req_ready), 32'(e_ready), n);
            if (e_chk_ma) chk("ma", 32'(ma), 32'(e_ma), n);
            if (e_chk_dq) chk("dq_out", 32'(dq_out), 32'(e_dq), n);
            if (e_chk_rd) chk("rsp_rdata_reset", 32'(rsp_rdata), 32'(e_rd), n);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 32'(rsp_valid), 32'd0, n);
                end else begin
                    chk("rsp_cycle", 32'(n), 32'(sb[0].lbl), n);
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rd), n);
                    void'(sb.pop_front());
                end
            end
            while (sb.size() > 0 && sb[0].lbl < n) begin
                chk("rsp_missing", 32'(rsp_valid), 32'd1, sb[0].lbl);
                void'(sb.pop_front());
            end
        end
        dq_in = pat(n);
    end

    task automatic send(bit we, logic [20:0] addr, logic [15:0] wd);
        int k;
        bit hs;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
        k = 0; hs = 0;
        while (!hs && k < 100) begin
            hs = req_ready;
            @(negedge clk);
            k++;
        end
        chk("send_handshake", 32'(hs), 32'd1, n);
    endtask

    task automatic idle(int c);
        req_valid = 0;
        repeat (c) @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; dq_in = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        send(0, {3'd5, 9'h1A3, 9'h05C}, 16'h0000);
        idle(8);
        send(1, {3'd0, 9'h011, 9'h022}, 16'h1234);
        idle(8);
        send(0, 21'($urandom()), 16'($urandom()));
        send(1, 21'($urandom()), 16'($urandom()));
        idle(130);
        k = 0;
        while (n % RI != RI - 4 && k < 200) begin @(negedge clk); k++; end
        send(0, 21'($urandom()), 16'h0);
        send(1, 21'($urandom()), 16'($urandom()));
        idle(12);
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom()), 21'($urandom()), 16'($urandom()));
            idle($urandom_range(0, 4));
        end
        send(0, {3'd7, 9'h0AA, 9'h155}, 16'h0);
        idle(2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        send(0, {3'd2, 9'h100, 9'h003}, 16'h0);
        idle(10);
        chk("sb_drained", 32'(sb.size()), 32'd0, n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", n);
        $fatal(1, "watchdog");
    end
endmodule
